// File: rtl/float2int_pkg.sv
// Shared constants, stage types and input classifier for the float-to-uint8 converter.
// Latency: none (declarations and a combinational helper only).
// Backpressure: not applicable.
package float2int_pkg;

   localparam int FLT_W    = 32;
   localparam int EXP_W    = 8;
   localparam int MAN_W    = 23;
   localparam int EXP_BIAS = 127;

   localparam logic [7:0]       UINT8_MAX   = 8'd255;
   localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

   // Exponent of 2^-1: anything below this is under one half and rounds to 0.
   localparam logic [EXP_W-1:0] EXP_HALF = 8'(EXP_BIAS - 1);
   // Exponent of 2^8: anything at or above this cannot fit in 8 bits.
   localparam logic [EXP_W-1:0] EXP_OVF  = 8'(EXP_BIAS + 8);
   // Right-shift of {1,mantissa} is SHIFT_BASE - exp.
   localparam logic [EXP_W-1:0] SHIFT_BASE = 8'(EXP_BIAS + MAN_W);

   typedef enum logic [2:0] {
      CLS_ZERO,   // +/-0, denormal, or positive value below one half
      CLS_NORM,   // positive value in [0.5, 256) needing shift/round
      CLS_OVF,    // +Inf or positive value >= 256
      CLS_NEG,    // negative nonzero (incl. -Inf, negative denormals)
      CLS_NAN     // any NaN, either sign
   } f2i_cls_e;

   typedef struct packed {
      f2i_cls_e         cls;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } s1_t;

   function automatic f2i_cls_e classify(input logic [FLT_W-1:0] f);
      logic             sgn;
      logic [EXP_W-1:0] e;
      logic [MAN_W-1:0] m;
      sgn = f[FLT_W-1];
      e   = f[FLT_W-2:MAN_W];
      m   = f[MAN_W-1:0];
      if (e == EXP_SPECIAL && m != '0)  return CLS_NAN;
      if (sgn && (e != '0 || m != '0))  return CLS_NEG;
      if (e == EXP_SPECIAL)             return CLS_OVF;
      if (e < EXP_HALF)                 return CLS_ZERO;
      if (e >= EXP_OVF)                 return CLS_OVF;
      return CLS_NORM;
   endfunction

endpackage

// File: rtl/float2int_round.sv
// Rounds the aligned magnitude and applies class-based saturation for the S2 stage.
// Latency: combinational.
// Backpressure: none; the enclosing pipeline register handles stalls.
module f2i_round
   import float2int_pkg::*;
#(
   parameter int ROUND_MODE = 1
)
(
   input  f2i_cls_e   cls,
   input  logic [7:0] mag,
   input  logic       guard,
   input  logic       sticky,
   output logic [7:0] value,
   output logic       sat
);

   logic       round_up;
   logic [8:0] sum;

   // Ties go to even: a bare half rounds up only when the integer LSB is odd.
   assign round_up = (ROUND_MODE == 1) && guard && (sticky || mag[0]);
   assign sum      = {1'b0, mag} + {8'd0, round_up};

   // Select the final value by class; rounding carry past 255 saturates.
   always_comb begin
      value = '0;
      sat   = 1'b0;
      case (cls)
         CLS_NORM: begin
            if (sum[8]) begin
               value = UINT8_MAX;
               sat   = 1'b1;
            end else begin
               value = sum[7:0];
            end
         end
         CLS_OVF: begin
            value = UINT8_MAX;
            sat   = 1'b1;
         end
         CLS_NEG:  sat = 1'b1;
         default:  value = '0;
      endcase
   end

endmodule

// File: rtl/float2int.sv
// IEEE-754 single to unsigned 8-bit pixel converter with saturation/NaN flags and flag counter.
// Latency: 2 cycles (S1 classify/decode, S2 shift/round/saturate), 1 result per cycle.
// Backpressure: both stages stall together when the output is held; enable only gates acceptance.
module float2int
   import float2int_pkg::*;
#(
   parameter int ROUND_MODE = 1
)
(
   input  logic             clk,
   input  logic             resetn,
   input  logic             enable,
   input  logic [FLT_W-1:0] flt_value,
   input  logic             valid_in,
   output logic             ready_in,
   output logic [7:0]       int_value,
   output logic             valid_out,
   input  logic             ready_out,
   output logic             sat_flag,
   output logic             nan_flag,
   input  logic             clear_count,
   output logic [15:0]      sat_count
);

   logic       advance;
   logic       s1_vld;
   s1_t        s1_q;
   logic       s2_vld;

   logic [MAN_W:0]       sig;
   logic [2*MAN_W+1:0]   ext;
   logic [EXP_W-1:0]     sh_amt;
   logic [31:0]          aligned;
   logic [7:0]           rnd_value;
   logic                 rnd_sat;
   logic                 out_xfer;

   assign advance   = ~s2_vld | ready_out;
   assign ready_in  = enable & advance;
   assign valid_out = s2_vld;
   assign out_xfer  = s2_vld & ready_out;

   // Fixed point with 24 fraction bits: [31:24] integer part, [23] guard, [22:0] sticky.
   // Only NORM uses this, where the shift is 16..24 so the integer part fits in 8 bits.
   assign sig     = {1'b1, s1_q.man};
   assign ext     = {sig, 24'd0};
   assign sh_amt  = SHIFT_BASE - s1_q.exp;
   assign aligned = 32'(ext >> sh_amt);

   f2i_round #(.ROUND_MODE(ROUND_MODE)) u_round (
      .cls    (s1_q.cls),
      .mag    (aligned[31:24]),
      .guard  (aligned[23]),
      .sticky (|aligned[22:0]),
      .value  (rnd_value),
      .sat    (rnd_sat)
   );

   // S1: capture and classify the accepted float.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_vld <= 1'b0;
         s1_q   <= '{cls: CLS_ZERO, exp: '0, man: '0};
      end else if (advance) begin
         s1_vld <= valid_in & ready_in;
         if (valid_in & ready_in) begin
            s1_q.cls <= classify(flt_value);
            s1_q.exp <= flt_value[FLT_W-2:MAN_W];
            s1_q.man <= flt_value[MAN_W-1:0];
         end
      end
   end

   // S2: register the rounded result and flags; held while the output is stalled.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s2_vld    <= 1'b0;
         int_value <= '0;
         sat_flag  <= 1'b0;
         nan_flag  <= 1'b0;
      end else if (advance) begin
         s2_vld <= s1_vld;
         if (s1_vld) begin
            int_value <= rnd_value;
            sat_flag  <= rnd_sat;
            nan_flag  <= (s1_q.cls == CLS_NAN);
         end
      end
   end

   // Count delivered flagged results, saturating; clear wins over increment.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sat_count <= '0;
      end else if (clear_count) begin
         sat_count <= '0;
      end else if (out_xfer && (sat_flag || nan_flag) && sat_count != 16'hFFFF) begin
         sat_count <= sat_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_float2int.sv
// Directed self-checking bench for float2int (round-half-even and truncating instances).
// Latency: checks the 2-cycle accept-to-output timing on every directed vector.
// Backpressure: exercises output stalls, enable gating and mid-stream reset.
module tb_float2int;

   logic        clk = 1'b0;
   logic        resetn;
   logic        enable;
   logic [31:0] flt_value;
   logic        valid_in;
   logic        ready_out;
   logic        clear_count;

   logic        ready_in,  valid_out,  sat_flag,  nan_flag;
   logic [7:0]  int_value;
   logic [15:0] sat_count;

   logic        ready_in_t, valid_out_t, sat_flag_t, nan_flag_t;
   logic [7:0]  int_value_t;
   logic [15:0] sat_count_t;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   float2int #(.ROUND_MODE(1)) dut (
      .clk(clk), .resetn(resetn), .enable(enable), .flt_value(flt_value),
      .valid_in(valid_in), .ready_in(ready_in), .int_value(int_value),
      .valid_out(valid_out), .ready_out(ready_out), .sat_flag(sat_flag),
      .nan_flag(nan_flag), .clear_count(clear_count), .sat_count(sat_count)
   );

   float2int #(.ROUND_MODE(0)) dut_t (
      .clk(clk), .resetn(resetn), .enable(enable), .flt_value(flt_value),
      .valid_in(valid_in), .ready_in(ready_in_t), .int_value(int_value_t),
      .valid_out(valid_out_t), .ready_out(ready_out), .sat_flag(sat_flag_t),
      .nan_flag(nan_flag_t), .clear_count(clear_count), .sat_count(sat_count_t)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One isolated transfer: accept, confirm no output after 1 cycle, capture after 2.
   task automatic xfer(input logic [31:0] f, output logic [7:0] v, output logic s,
                       output logic n, output logic [7:0] vt, output logic st);
      @(negedge clk);
      flt_value = f;
      valid_in  = 1'b1;
      ready_out = 1'b1;
      #1;
      chk("acc_rdy", {31'd0, ready_in}, 32'd1);
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      chk("lat1_vld", {31'd0, valid_out}, 32'd0);
      @(posedge clk);
      #1;
      chk("lat2_vld", {31'd0, valid_out}, 32'd1);
      v  = int_value;
      s  = sat_flag;
      n  = nan_flag;
      vt = int_value_t;
      st = sat_flag_t;
   endtask

   typedef struct {
      logic [31:0] f;
      logic [7:0]  v;
      logic        s;
      logic        n;
      logic [7:0]  vt;
      logic        st;
      string       tag;
   } vec_t;

   vec_t vecs[13];
   logic [31:0] stream_f[10];

   initial begin
      logic [7:0] v, vt;
      logic       s, n, st;
      logic [7:0] held;
      logic       hold_chk;
      int         sent, rcvd, stale;
      logic       acc;

      //          float          v    s   n   vt   st
      vecs[0]  = '{32'h43000000, 128, 0, 0, 128, 0, "f128"};
      vecs[1]  = '{32'h437F0000, 255, 0, 0, 255, 0, "f255"};
      vecs[2]  = '{32'h3F800000, 1,   0, 0, 1,   0, "f1"};
      vecs[3]  = '{32'h00000000, 0,   0, 0, 0,   0, "f0"};
      vecs[4]  = '{32'h3FC00000, 2,   0, 0, 1,   0, "f1p5"};
      vecs[5]  = '{32'h40200000, 2,   0, 0, 2,   0, "f2p5"};
      vecs[6]  = '{32'h3F000000, 0,   0, 0, 0,   0, "f0p5"};
      vecs[7]  = '{32'h40600000, 4,   0, 0, 3,   0, "f3p5"};
      vecs[8]  = '{32'h437F8000, 255, 1, 0, 255, 0, "f255p5"};
      vecs[9]  = '{32'h7F800000, 255, 1, 0, 255, 1, "pinf"};
      vecs[10] = '{32'hBF800000, 0,   1, 0, 0,   1, "neg1"};
      vecs[11] = '{32'h80000000, 0,   0, 0, 0,   0, "negz"};
      vecs[12] = '{32'h7FC00000, 0,   0, 1, 0,   0, "nan"};

      stream_f = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                   32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};

      resetn      = 1'b0;
      enable      = 1'b1;
      flt_value   = '0;
      valid_in    = 1'b0;
      ready_out   = 1'b0;
      clear_count = 1'b0;
      #1;
      chk("rst_vld",   {31'd0, valid_out}, 32'd0);
      chk("rst_val",   {24'd0, int_value}, 32'd0);
      chk("rst_cnt",   {16'd0, sat_count}, 32'd0);
      chk("rst_flags", {30'd0, sat_flag, nan_flag}, 32'd0);
      chk("rst_rdy",   {31'd0, ready_in}, 32'd1);
      repeat (2) @(negedge clk);
      resetn = 1'b1;

      // Directed conversions, both rounding modes in parallel.
      foreach (vecs[i]) begin
         xfer(vecs[i].f, v, s, n, vt, st);
         chk({vecs[i].tag, "_val"},  {24'd0, v},  {24'd0, vecs[i].v});
         chk({vecs[i].tag, "_flag"}, {30'd0, s, n}, {30'd0, vecs[i].s, vecs[i].n});
         chk({vecs[i].tag, "_tval"}, {24'd0, vt}, {24'd0, vecs[i].vt});
         chk({vecs[i].tag, "_tsat"}, {31'd0, st}, {31'd0, vecs[i].st});
      end
      repeat (3) @(negedge clk);
      chk("cnt_rne",   {16'd0, sat_count},   32'd4);
      chk("cnt_trunc", {16'd0, sat_count_t}, 32'd3);

      // Clear coincident with a flagged transfer.
      xfer(32'h7F800000, v, s, n, vt, st);
      clear_count = 1'b1;
      @(posedge clk);
      #1;
      clear_count = 1'b0;
      chk("clr_coinc", {16'd0, sat_count}, 32'd0);

      // Enable low blocks acceptance only.
      @(negedge clk);
      enable = 1'b0;
      #1;
      chk("en_rdy", {31'd0, ready_in}, 32'd0);
      enable = 1'b1;

      // Stream of 1.0..10.0 with a 3-cycle output stall.
      sent = 0; rcvd = 0; hold_chk = 1'b0; held = '0;
      for (int cyc = 0; cyc < 60 && rcvd < 10; cyc++) begin
         @(negedge clk);
         ready_out = !(cyc >= 6 && cyc <= 8);
         valid_in  = (sent < 10);
         if (sent < 10) flt_value = stream_f[sent];
         #1;
         if (hold_chk) begin
            chk("hold_val", {24'd0, int_value}, {24'd0, held});
            chk("hold_vld", {31'd0, valid_out}, 32'd1);
            hold_chk = 1'b0;
         end
         if (valid_out && !ready_out) begin
            held     = int_value;
            hold_chk = 1'b1;
            chk("stall_rdy", {31'd0, ready_in}, 32'd0);
         end
         if (valid_out && ready_out) begin
            chk("order", {24'd0, int_value}, rcvd + 1);
            rcvd++;
         end
         acc = valid_in & ready_in;
         @(posedge clk);
         if (acc) sent++;
      end
      valid_in = 1'b0;
      chk("rx_cnt", rcvd, 32'd10);
      chk("tx_cnt", sent, 32'd10);

      // Reset with two results in flight.
      @(negedge clk);
      ready_out = 1'b0;
      valid_in  = 1'b1;
      flt_value = 32'h40000000;
      @(negedge clk);
      flt_value = 32'h40400000;
      @(negedge clk);
      valid_in = 1'b0;
      #1;
      chk("pre_rst_vld", {31'd0, valid_out}, 32'd1);
      resetn = 1'b0;
      #1;
      chk("mid_rst_vld", {31'd0, valid_out}, 32'd0);
      chk("mid_rst_val", {24'd0, int_value}, 32'd0);
      @(negedge clk);
      resetn    = 1'b1;
      ready_out = 1'b1;
      #1;
      chk("rel_rdy", {31'd0, ready_in}, 32'd1);
      stale = 0;
      repeat (5) begin
         @(negedge clk);
         if (valid_out) stale++;
      end
      chk("no_stale", stale, 32'd0);
      xfer(32'h40400000, v, s, n, vt, st);
      chk("post_rst_val", {24'd0, v}, 32'd3);

      // Counter saturation: well over 65536 flagged transfers.
      @(negedge clk);
      chk("cnt_pre_sat", {16'd0, sat_count}, 32'd0);
      flt_value = 32'h7F800000;
      valid_in  = 1'b1;
      ready_out = 1'b1;
      repeat (65540) @(negedge clk);
      valid_in = 1'b0;
      repeat (4) @(negedge clk);
      chk("cnt_sat",   {16'd0, sat_count},   32'h0000FFFF);
      chk("cnt_sat_t", {16'd0, sat_count_t}, 32'h0000FFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/float2int.md
FLOAT2INT -- requirements
Module: float2int

Interface
REQ-001 SHALL have parameter ROUND_MODE, default 1, meaning 0 = truncate toward zero, 1 = round-half-to-even.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port enable  input  1  block enable; low blocks acceptance of new data.
REQ-005 SHALL have port flt_value  input  32  IEEE-754 single {sign, exp[7:0], mantissa[22:0]}.
REQ-006 SHALL have port valid_in  input  1  flt_value valid.
REQ-007 SHALL have port ready_in  output  1  block accepts flt_value this cycle.
REQ-008 SHALL have port int_value  output  8  unsigned 8-bit pixel result.
REQ-009 SHALL have port valid_out  output  1  int_value valid.
REQ-010 SHALL have port ready_out  input  1  downstream accepts int_value.
REQ-011 SHALL have port sat_flag  output  1  result clamped (negative, overflow, or +Inf); qualified by valid_out.
REQ-012 SHALL have port nan_flag  output  1  input was NaN; qualified by valid_out.
REQ-013 SHALL have port clear_count  input  1  single-cycle pulse, clears sat_count.
REQ-014 SHALL have port sat_count  output  16  count of delivered results with sat_flag or nan_flag.

Function
REQ-015 SHALL be a 2-stage pipeline: S1 classify/decode, S2 shift/round/saturate; latency 2 cycles from accept to valid_out with no stall.
REQ-016 SHALL transfer in on valid_in & ready_in, out on valid_out & ready_out.
REQ-017 SHALL compute advance = ~S2.valid | ready_out; ready_in = enable & advance; both stages stall together when advance=0.
REQ-018 SHALL hold int_value, flags, valid_out stable while valid_out=1 and ready_out=0.
REQ-019 SHALL sustain 1 result/cycle with ready_out held high and valid_in held high.
REQ-020 SHALL keep draining in-flight data while enable=0; only acceptance is blocked.
REQ-021 SHALL map exp=255, mantissa!=0 (NaN) -> 0, nan_flag=1, sat_flag=0.
REQ-022 SHALL map +Inf -> 255, sat_flag=1.
REQ-023 SHALL map sign=1 with nonzero magnitude (incl. -Inf, negative denormals) -> 0, sat_flag=1; -0.0 -> 0, no flag.
REQ-024 SHALL map exp=0 (zero/denormal) -> 0, no flag.
REQ-025 SHALL form magnitude {1,mantissa} and shift right by (150 - exp); exp<126 -> 0 (after rounding), no flag.
REQ-026 SHALL with ROUND_MODE=1 round on guard/sticky bits, ties to even; ROUND_MODE=0 discard fraction.
REQ-027 SHALL saturate to 255 with sat_flag=1 when rounded result >255 (exp>=135 or round carry).
REQ-028 SHALL increment sat_count on each output transfer with sat_flag|nan_flag, saturating at 16'hFFFF.
REQ-029 SHALL give clear_count priority over simultaneous increment (result 0).

Reset
REQ-030 SHALL on resetn=0 immediately clear both stage valids, valid_out=0, int_value=0, sat_flag=0, nan_flag=0, sat_count=0.
REQ-031 SHALL drop in-flight data on reset mid-operation; no output after reset release until new accept.
REQ-032 SHALL drive ready_in per REQ-017 from reset release (high if enable=1).

Structure
REQ-033 SHALL place constants in a shared package: FLT_W=32, EXP_W=8, MAN_W=23, EXP_BIAS=127, UINT8_MAX=255, NaN/Inf exponent code.
REQ-034 SHALL put S2 rounding/saturation in combinational sub-module f2i_round (inputs shifted magnitude, guard, sticky, class; outputs value, sat).
REQ-035 SHALL keep pipeline control and sat_count in float2int top.

Verification
REQ-036 SHALL check exact values: 0x43000000 -> 128; 0x437F0000 -> 255; 0x3F800000 -> 1; 0x00000000 -> 0; all 2 cycles after accept.
REQ-037 SHALL check rounding, ROUND_MODE=1: 0x3FC00000 (1.5) -> 2; 0x40200000 (2.5) -> 2; 0x3F000000 (0.5) -> 0; ROUND_MODE=0: 1.5 -> 1.
REQ-038 SHALL check specials: 0x437F8000 (255.5) -> 255 sat; 0x7F800000 -> 255 sat; 0xBF800000 -> 0 sat; 0x80000000 -> 0 no flag; 0x7FC00000 -> 0 nan; sat_count=4.
REQ-039 SHALL check backpressure: stream 10 values, ready_out low 3 cycles mid-stream -> outputs held stable, ready_in low, no loss/duplication, order preserved.
REQ-040 SHALL check reset mid-stream with 2 in flight -> valid_out=0 immediately, no stale output after release.
REQ-041 SHALL check clear_count coincident with flagged transfer -> sat_count=0; 65536 flagged transfers -> sat_count holds 0xFFFF.
